// File: rtl/mult_iterative_if.sv
// mult_iterative_if
// Handshake bundle for the iterative multiplier.
//   in_valid/in_ready  : operand handshake (a, b)
//   out_valid/out_ready: product handshake (product)
// master modport = operand producer / product consumer, slave modport = multiplier.
interface mult_iterative_if #(
  parameter int WIDTH = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     product;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/mult_iterative.sv
// mult_iterative
// Iterative WIDTH x WIDTH -> 2*WIDTH multiplier. Each CALC cycle consumes one
// DIGIT-wide slice of the multiplier, so a product takes N = WIDTH/DIGIT cycles.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : mult_iterative_if.slave (in_valid/in_ready/a/b, out_valid/out_ready/product)
// Build option:
//   MULT_SIGNED_EN : two's-complement operands/product (sign-magnitude internally).
//                    Undefined -> unsigned, no sign logic.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | in_ready=1, waiting for operands
// CALC   | accumulating one multiplier digit per cycle (k = 0..N-1)
// DONE   | out_valid=1, product held until out_ready
module mult_iterative #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 4
) (
  input logic            clk,
  input logic            rst_n,
  mult_iterative_if.slave bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH+DIGIT-1:0] pp;
  logic [2*WIDTH-1:0]     pp_shift;
  logic [2*WIDTH-1:0]     acc_next;
  logic [2*WIDTH-1:0]     result;
  logic [WIDTH-1:0]       a_in;
  logic [WIDTH-1:0]       b_in;

`ifdef MULT_SIGNED_EN
  logic sign_q, sign_d;

  // Magnitudes fit in WIDTH bits unsigned, including -2^(WIDTH-1).
  always_comb begin
    a_in = bus.a[WIDTH-1] ? (~bus.a + WIDTH'(1)) : bus.a;
    b_in = bus.b[WIDTH-1] ? (~bus.b + WIDTH'(1)) : bus.b;
  end
`else
  always_comb begin
    a_in = bus.a;
    b_in = bus.b;
  end
`endif

  // b_q shifts right each step, so the current digit is always its low slice.
  always_comb begin
    pp       = {{DIGIT{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q[DIGIT-1:0]};
    pp_shift = (2*WIDTH)'(pp) << (DIGIT * int'(k_q));
    acc_next = acc_q + pp_shift;
`ifdef MULT_SIGNED_EN
    result   = sign_q ? (~acc_next + (2*WIDTH)'(1)) : acc_next;
`else
    result   = acc_next;
`endif
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    product_d = product_q;
`ifdef MULT_SIGNED_EN
    sign_d    = sign_q;
`endif
    case (state_q)
      S_IDLE: begin
        // in_ready is 1 throughout IDLE, so in_valid alone completes the handshake.
        if (bus.in_valid) begin
          a_d     = a_in;
          b_d     = b_in;
          acc_d   = '0;
          k_d     = '0;
          state_d = S_CALC;
`ifdef MULT_SIGNED_EN
          sign_d  = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
`endif
        end
      end
      S_CALC: begin
        acc_d = acc_next;
        b_d   = b_q >> DIGIT;
        k_d   = k_q + KW'(1);
        if (k_q == KW'(N - 1)) begin
          k_d       = '0;
          product_d = result;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      product_q <= '0;
`ifdef MULT_SIGNED_EN
      sign_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      product_q <= product_d;
`ifdef MULT_SIGNED_EN
      sign_q    <= sign_d;
`endif
    end
  end

  // Outputs come straight from state/registers; no input-to-output paths.
  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.product   = product_q;

endmodule

// File: tb/tb_mult_iterative.sv
// tb_mult_iterative
// Directed and randomised checks of mult_iterative for WIDTH=8/DIGIT=4 and
// WIDTH=16/DIGIT=4. Expected products come from plain integer arithmetic.
// Honours MULT_SIGNED_EN for the expected values.
module tb_mult_iterative;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  mult_iterative_if #(.WIDTH(8))  bus8 ();
  mult_iterative_if #(.WIDTH(16)) bus16 ();

  mult_iterative #(.WIDTH(8), .DIGIT(4)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  mult_iterative #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y);
`ifdef MULT_SIGNED_EN
    logic signed [15:0] p;
    p = $signed(x) * $signed(y);
    return p;
`else
    return {8'b0, x} * {8'b0, y};
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one operation on the 8-bit unit with out_ready high; check latency and result.
  task automatic run8(input string tag, input logic [7:0] x, input logic [7:0] y,
                      input logic [15:0] exp);
    int lat;
    bus8.a         = x;
    bus8.b         = y;
    bus8.in_valid  = 1'b1;
    bus8.out_ready = 1'b1;
    step();
    bus8.in_valid = 1'b0;
    lat = 0;
    while (!bus8.out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, "_valid"}, 64'(bus8.out_valid), 64'd1);
    chk({tag, "_lat"}, 64'(lat), 64'd2);
    chk({tag, "_prod"}, 64'(bus8.product), 64'(exp));
    step();
  endtask

  task automatic run16(input string tag, input logic [15:0] x, input logic [15:0] y,
                       input logic [31:0] exp);
    int lat;
    bus16.a         = x;
    bus16.b         = y;
    bus16.in_valid  = 1'b1;
    bus16.out_ready = 1'b1;
    step();
    bus16.in_valid = 1'b0;
    lat = 0;
    while (!bus16.out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, "_valid"}, 64'(bus16.out_valid), 64'd1);
    chk({tag, "_lat"}, 64'(lat), 64'd4);
    chk({tag, "_prod"}, 64'(bus16.product), 64'(exp));
    step();
  endtask

  initial begin
    logic [15:0] expq[$];
    int accepted;
    int consumed;
    logic [15:0] exp_ff;
    logic [31:0] exp_w16;

    rst_n = 1'b0;
    bus8.in_valid = 1'b0;  bus8.out_ready = 1'b0;  bus8.a = '0;  bus8.b = '0;
    bus16.in_valid = 1'b0; bus16.out_ready = 1'b0; bus16.a = '0; bus16.b = '0;
    #2;
    chk("rst_in_ready", 64'(bus8.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus8.out_valid), 64'd0);
    chk("rst_product", 64'(bus8.product), 64'd0);
    chk("rst16_product", 64'(bus16.product), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 0xFF * 0xFF with out_ready held high
`ifdef MULT_SIGNED_EN
    exp_ff = 16'h0001;
`else
    exp_ff = 16'hFE01;
`endif
    bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.in_valid = 1'b1; bus8.out_ready = 1'b1;
    step();
    bus8.in_valid = 1'b0;
    bus8.a = 8'h11; bus8.b = 8'h22;
    chk("ff_calc_in_ready", 64'(bus8.in_ready), 64'd0);
    chk("ff_calc_out_valid", 64'(bus8.out_valid), 64'd0);
    step();
    chk("ff_edge1_out_valid", 64'(bus8.out_valid), 64'd0);
    chk("ff_edge1_in_ready", 64'(bus8.in_ready), 64'd0);
    step();
    chk("ff_edge2_out_valid", 64'(bus8.out_valid), 64'd1);
    chk("ff_edge2_in_ready", 64'(bus8.in_ready), 64'd0);
    chk("ff_product", 64'(bus8.product), 64'(exp_ff));
    step();
    chk("ff_idle_out_valid", 64'(bus8.out_valid), 64'd0);
    chk("ff_idle_in_ready", 64'(bus8.in_ready), 64'd1);
    chk("ff_idle_product", 64'(bus8.product), 64'(exp_ff));

    // Back-pressure: product held, in_valid ignored while in DONE
    bus8.a = 8'h12; bus8.b = 8'h34; bus8.in_valid = 1'b1; bus8.out_ready = 1'b0;
    step();
    bus8.in_valid = 1'b0;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 64'(bus8.out_valid), 64'd1);
      chk("bp_product", 64'(bus8.product), 64'h03A8);
      chk("bp_in_ready", 64'(bus8.in_ready), 64'd0);
      bus8.in_valid = i[0];
      bus8.a = 8'h55; bus8.b = 8'h66;
      step();
    end
    chk("bp_still_valid", 64'(bus8.out_valid), 64'd1);
    chk("bp_still_product", 64'(bus8.product), 64'h03A8);
    bus8.in_valid = 1'b1;
    bus8.out_ready = 1'b1;
    step();
    bus8.in_valid = 1'b0;
    chk("bp_consume_in_ready", 64'(bus8.in_ready), 64'd1);
    chk("bp_consume_out_valid", 64'(bus8.out_valid), 64'd0);
    chk("bp_consume_product", 64'(bus8.product), 64'h03A8);
    step();
    chk("bp_no_accept_on_consume", 64'(bus8.in_ready), 64'd1);

    // Reset during CALC
    bus8.a = 8'hAB; bus8.b = 8'hCD; bus8.in_valid = 1'b1; bus8.out_ready = 1'b1;
    step();
    bus8.in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("rst_calc_out_valid", 64'(bus8.out_valid), 64'd0);
    chk("rst_calc_product", 64'(bus8.product), 64'd0);
    chk("rst_calc_in_ready", 64'(bus8.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run8("post_rst", 8'd3, 8'd7, 16'h0015);

`ifdef MULT_SIGNED_EN
    run8("s_m3x5", 8'hFD, 8'h05, 16'hFFF1);
    run8("s_minxmin", 8'h80, 8'h80, 16'h4000);
    run8("s_maxxmin", 8'h7F, 8'h80, 16'hC080);
    exp_w16 = 32'hFFFF_FFFF;
`else
    exp_w16 = 32'h0000_FFFF;
`endif
    run8("mix", 8'hC3, 8'h5A, ref8(8'hC3, 8'h5A));

    run16("w16_ffff_x1", 16'hFFFF, 16'h0001, exp_w16);
    run16("w16_8000sq", 16'h8000, 16'h8000, 32'h4000_0000);

    // Randomised traffic on the 8-bit unit against an in-order queue of a*b
    accepted = 0;
    consumed = 0;
    for (int cyc = 0; cyc < 60000 && consumed < 10000; cyc++) begin
      bus8.in_valid  = ($urandom_range(0, 7) != 0) && (accepted < 10000);
      bus8.a         = 8'($urandom);
      bus8.b         = 8'($urandom);
      bus8.out_ready = ($urandom_range(0, 7) != 0);
      if (bus8.out_valid) begin
        if (expq.size() == 0) begin
          chk("rnd_spurious_valid", 64'(bus8.out_valid), 64'd0);
        end else begin
          chk("rnd_product", 64'(bus8.product), 64'(expq[0]));
          if (bus8.out_ready) begin
            void'(expq.pop_front());
            consumed++;
          end
        end
      end
      if (bus8.in_valid && bus8.in_ready) begin
        expq.push_back(ref8(bus8.a, bus8.b));
        accepted++;
      end
      step();
    end
    bus8.in_valid = 1'b0;
    bus8.out_ready = 1'b0;
    chk("rnd_consumed", 64'(consumed), 64'd10000);
    chk("rnd_left_over", 64'(expq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_iterative.md
# mult_iterative

Parametrised, iterative integer multiplier for the neural-network datapath. It computes a WIDTH×WIDTH → 2·WIDTH product by accumulating one DIGIT-wide slice of the multiplier per clock. This trades the area of a fully combinational array for WIDTH/DIGIT cycles of latency. It sits between the weight/activation fetch stage and the neuron accumulator, with valid/ready handshakes on both sides, and replaces the fixed 8-bit combinational multiplier wherever a wider or cheaper multiplier is needed.

## Interface
- WIDTH, 8: operand width in bits; must be a multiple of DIGIT and ≥ DIGIT.
- DIGIT, 4: multiplier slice consumed per cycle; N = WIDTH/DIGIT is the iteration count.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operands a/b present.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- product  out  2·WIDTH  result of a·b.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid&&in_ready, latch a and b into internal registers, clear the accumulator, set step counter k=0, and go to CALC.
  - Operand changes after acceptance are ignored.
- CALC:
  - in_ready=0, out_valid=0.
  - Each edge: acc += a_reg · b_reg[k·DIGIT +: DIGIT], shifted left by k·DIGIT; then k++.
  - After the step with k=N-1, go to DONE.
  - The accumulator is 2·WIDTH bits wide; the sum never overflows it.
- DONE:
  - out_valid=1 and product=acc, held stable until an edge with out_ready=1.
  - That edge returns the FSM to IDLE and drops out_valid.
  - product keeps its last value in IDLE.
- Simultaneous events: in_valid is ignored outside IDLE. No new operands are accepted in the cycle the product is consumed; acceptance happens on a later edge in IDLE.
- Reset (at any time, including mid-CALC or in DONE):
  - state=IDLE, k=0, accumulator=0, product=0, out_valid=0, in_ready=1.
  - Any in-flight operation is abandoned; no partial product is ever presented.
- Reset values of outputs: in_ready=1, out_valid=0, product=0.

## Timing
- Latency: out_valid rises exactly N rising edges after the accepting edge. For WIDTH=8, DIGIT=4 that is 2 edges; for WIDTH=16, DIGIT=4 it is 4.
- Throughput: at most one product per N+2 cycles with out_ready held high (accept, N calc edges, consume edge).
- Outputs are registered or decoded directly from state, with no combinational path from inputs to outputs.
- Critical path per cycle: one WIDTH×DIGIT partial product plus a 2·WIDTH adder.

## Configuration
- MULT_SIGNED_EN defined:
  - a, b and product are two's-complement.
  - At acceptance the block latches |a| and |b| and the sign s = a[MSB]^b[MSB].
  - The magnitudes are multiplied iteratively; in the DONE transition the accumulator is negated if s=1.
  - −2^(WIDTH−1)·−2^(WIDTH−1) = 2^(2·WIDTH−2) must be exact.
  - Latency is unchanged.
- MULT_SIGNED_EN undefined:
  - Operands and product are unsigned.
  - No sign logic is synthesised.

## Test plan
- Unsigned, WIDTH=8/DIGIT=4: a=0xFF, b=0xFF, out_ready=1 → out_valid exactly 2 edges after acceptance, product=0xFE01; in_ready=0 from acceptance until the edge after consumption.
- Back-pressure: a=0x12, b=0x34, out_ready=0 for 5 cycles → product=0x03A8 held stable with out_valid=1 for all 5 cycles; in_valid pulses during this window are not accepted; out_ready=1 → IDLE next edge.
- Reset mid-CALC: assert rst_n=0 one edge after accepting a=0xAB, b=0xCD → immediately out_valid=0, product=0, in_ready=1; after release, a=3, b=7 → product=0x0015 with no stale data.
- MULT_SIGNED_EN, WIDTH=8: (−3)·5 → 0xFFF1; (−128)·(−128) → 0x4000; 127·(−128) → 0xC080.
- WIDTH=16/DIGIT=4: a=0xFFFF, b=0x0001 → product=0x0000FFFF after 4 edges; 0x8000·0x8000 unsigned → 0x40000000.
- Randomised: 10,000 back-to-back operations with random in_valid/out_ready patterns, checked against a behavioural a·b reference. No lost or duplicated products; results in order.
